pn_frame_sequencer: RTL and testbench

- Frame-level controller for the 5-stage PN generator, which uses polynomial x^5+x^3+1, period 31, seed state 1,0,1,1,0 and a serial output bit.
- On each start request it reseeds the generator and streams exactly frame_len PN bits out through a valid/ready interface. It advances the generator only on accepted bits.
- Sits between the generator and the scrambler/Hamming encoder datapath. The generator is instantiated beside this block in the parent.

---
 rtl/pnseq_pkg.sv | 22 ++
 rtl/pn_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_pn_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pnseq_pkg.sv
// Shared definitions for the PN frame sequencer.
// Contents:
//   state_e    - controller states (IDLE=0, RESEED=1, RUN=2, DONE=3)
//   PN_PERIOD  - period of the x^5+x^3+1 generator
//   PN_SEED    - generator seed, reg4..reg0 (serial output order 1,0,1,1,0)
//   DEF_LEN_W / DEF_CNT_W - default widths for frame length and frame counter
package pnseq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReseed = 2'd1,
        StRun    = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam int unsigned PN_PERIOD = 31;
    localparam logic [4:0]  PN_SEED   = 5'b01101;

    localparam int unsigned DEF_LEN_W = 10;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/pn_frame_sequencer.sv
// Frame-level controller for a sibling 5-stage PN generator. Each start request
// reseeds the generator for one cycle, then streams frame_len bits over a
// valid/ready handshake, stepping the generator only on accepted bits.
//
// Optional feature: define PNSEQ_FRAME_CNT_EN to add the frame_cnt output
// (completed frames, wraps modulo 2^CNT_W, not bumped by aborts).
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - frame request, sampled in IDLE only
//   frame_len     - bits in the frame, sampled with start (0 is ignored)
//   abort         - cancel the frame while in RESEED or RUN
//   pn_in         - generator serial output
//   pn_en         - generator step enable (one per accepted bit)
//   pn_rst        - registered generator reseed
//   bit_valid     - bit_out is valid (RUN)
//   bit_out       - current PN bit
//   bit_ready     - downstream accepts bit_out
//   busy          - high in RESEED and RUN
//   done          - one-cycle pulse after the last bit is accepted
//   aborted       - one-cycle pulse after an abort
//   frame_cnt     - completed frame count (PNSEQ_FRAME_CNT_EN only)
module pn_frame_sequencer
    import pnseq_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
`ifdef PNSEQ_FRAME_CNT_EN
    ,
    parameter int unsigned CNT_W = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic             pn_in,
    output logic             pn_en,
    output logic             pn_rst,
    output logic             bit_valid,
    output logic             bit_out,
    input  logic             bit_ready,
    output logic             busy,
    output logic             done,
    output logic             aborted
`ifdef PNSEQ_FRAME_CNT_EN
    ,
    output logic [CNT_W-1:0] frame_cnt
`endif
);

    state_e           state_q;
    logic [LEN_W-1:0] count_q;
    logic             pn_rst_q;
    logic             bit_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;

    logic             accept;
    logic             last_accept;

    assign accept      = bit_valid_q & bit_ready;
    // Completion needs the last bit accepted without a coincident abort.
    assign last_accept = (state_q == StRun) && accept && !abort &&
                         (count_q == LEN_W'(1));

    assign pn_en     = accept;
    assign pn_rst    = pn_rst_q;
    assign bit_valid = bit_valid_q;
    assign bit_out   = pn_in;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            pn_rst_q    <= 1'b1;  // hold the generator at its seed during reset
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            pn_rst_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && (frame_len != '0)) begin
                        count_q  <= frame_len;
                        state_q  <= StReseed;
                        pn_rst_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StReseed: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q     <= StRun;
                        bit_valid_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        bit_valid_q <= 1'b0;
                        aborted_q   <= 1'b1;
                    end else if (last_accept) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        bit_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        count_q     <= '0;
                    end else if (accept) begin
                        count_q <= count_q - LEN_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef PNSEQ_FRAME_CNT_EN
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (last_accept) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pn_frame_sequencer.sv
// Self-checking bench for pn_frame_sequencer. A behavioural stand-in for the
// sibling PN generator drives pn_in; expected bits come from the m-sequence
// recurrence of x^5+x^3+1 and are queued per frame, and a monitor pops and
// compares on every accepted bit and every done/aborted pulse.
// Define PNSEQ_FRAME_CNT_EN to also check frame_cnt (CNT_W=2).
module tb_pn_frame_sequencer;

    localparam int unsigned LEN_W    = 10;
    localparam int          EV_DONE  = 0;
    localparam int          EV_ABORT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             abort;
    logic             pn_in;
    logic             pn_en;
    logic             pn_rst;
    logic             bit_valid;
    logic             bit_out;
    logic             bit_ready;
    logic             busy;
    logic             done;
    logic             aborted;
`ifdef PNSEQ_FRAME_CNT_EN
    localparam int unsigned CNT_W = 2;
    logic [CNT_W-1:0] frame_cnt;
    int               exp_frames = 0;
`endif

    int errors = 0;
    int checks = 0;
    int pn_en_seen = 0;
    int m_seq[31];
    bit exp_bits[$];
    int exp_ev[$];

    always #5 clk = ~clk;

    pn_frame_sequencer #(
        .LEN_W(LEN_W)
`ifdef PNSEQ_FRAME_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .frame_len(frame_len),
        .abort(abort),
        .pn_in(pn_in),
        .pn_en(pn_en),
        .pn_rst(pn_rst),
        .bit_valid(bit_valid),
        .bit_out(bit_out),
        .bit_ready(bit_ready),
        .busy(busy),
        .done(done),
        .aborted(aborted)
`ifdef PNSEQ_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    // Stand-in generator: reg0 is the serial output, feedback enters reg4.
    logic [4:0] gen_q;
    always @(posedge clk) begin
        if (pn_rst) gen_q <= 5'b01101;
        else if (pn_en) gen_q <= {gen_q[0] ^ gen_q[3], gen_q[4:1]};
    end
    assign pn_in = gen_q[0];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: sample mid-cycle, well away from the active edge.
    always @(negedge clk) begin
        bit eb;
        int ev;
        if (!rst) begin
            if (pn_en) pn_en_seen++;
            if (bit_valid && bit_ready) begin
                chk("pn_en_on_accept", int'(pn_en), 1);
                if (exp_bits.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    eb = exp_bits.pop_front();
                    chk("bit_out", int'(bit_out), int'(eb));
                end
            end else begin
                chk("pn_en_no_accept", int'(pn_en), 0);
            end
            if (done) begin
                chk("busy_at_done", int'(busy), 0);
                if (exp_ev.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    ev = exp_ev.pop_front();
                    chk("event_done", ev, EV_DONE);
                end
            end
            if (aborted) begin
                if (exp_ev.size() == 0) chk("unexpected_abort", 1, 0);
                else begin
                    ev = exp_ev.pop_front();
                    chk("event_abort", ev, EV_ABORT);
                end
            end
        end
    end

    // mode: 0 ready held high, 1 random ready plus start noise, 2 fixed pattern.
    task automatic run_frame(input int len, input int abort_at, input int mode);
        int  n_exp, acc, cyc, pidx, base;
        bit  ended, rdy;
        bit  pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        n_exp = (abort_at != 0) ? abort_at : len;
        tick();
        for (int i = 0; i < n_exp; i++) exp_bits.push_back(m_seq[i % 31] != 0);
        exp_ev.push_back((abort_at != 0) ? EV_ABORT : EV_DONE);
        base      = pn_en_seen;
        start     = 1'b1;
        frame_len = LEN_W'(len);
        acc       = 0;
        pidx      = 0;
        ended     = 1'b0;
        for (cyc = 1; cyc <= 600; cyc++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (cyc == 1) begin
                chk("pn_rst_in_reseed", int'(pn_rst), 1);
                chk("busy_in_reseed", int'(busy), 1);
                chk("valid_in_reseed", int'(bit_valid), 0);
            end
            if (cyc == 2) begin
                chk("pn_rst_in_run", int'(pn_rst), 0);
                chk("valid_in_run", int'(bit_valid), 1);
            end
            if (done || aborted) begin
                ended = 1'b1;
                break;
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom % 3) != 0;
            else begin
                rdy = (bit_valid && pidx < 7) ? pat[pidx] : 1'b1;
                if (bit_valid) pidx++;
            end
            bit_ready = rdy;
            if (bit_valid && rdy) begin
                acc++;
                if (abort_at != 0 && acc == abort_at) abort = 1'b1;
            end
            if (mode == 1 && ($urandom % 5) == 0) begin
                start     = 1'b1;
                frame_len = LEN_W'($urandom_range(1, 40));
            end
        end
        if (!ended) chk("frame_timeout", 0, 1);
        if (ended && mode == 0 && abort_at == 0) chk("frame_cycles", cyc, len + 2);
        chk("pn_en_count", pn_en_seen - base, n_exp);
`ifdef PNSEQ_FRAME_CNT_EN
        if (done) exp_frames = (exp_frames + 1) % (1 << CNT_W);
        chk("frame_cnt", int'(frame_cnt), exp_frames);
`endif
        if (mode == 1 && done) begin
            start     = 1'b1;
            frame_len = LEN_W'($urandom_range(1, 40));
            tick();
            start = 1'b0;
            chk("start_in_done_ignored", int'(busy), 0);
        end
    endtask

    initial begin
        int len, ab;
        m_seq[0] = 1; m_seq[1] = 0; m_seq[2] = 1; m_seq[3] = 1; m_seq[4] = 0;
        for (int n = 0; n + 5 < 31; n++) m_seq[n + 5] = m_seq[n + 3] ^ m_seq[n];

        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_ready = 1'b0; frame_len = '0;
        repeat (3) tick();
        chk("rst_pn_rst", int'(pn_rst), 1);
        chk("rst_valid", int'(bit_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_pn_en", int'(pn_en), 0);
`ifdef PNSEQ_FRAME_CNT_EN
        chk("rst_frame_cnt", int'(frame_cnt), 0);
`endif
        rst = 1'b0;
        tick();
        chk("idle_pn_rst", int'(pn_rst), 0);

        run_frame(6, 0, 0);
        run_frame(32, 0, 0);
        run_frame(4, 0, 2);
        run_frame(10, 3, 0);
        run_frame(3, 0, 0);

        // Zero-length start is ignored.
        tick();
        start = 1'b1; frame_len = '0;
        tick();
        start = 1'b0;
        chk("len0_busy", int'(busy), 0);
        chk("len0_pn_rst", int'(pn_rst), 0);
        tick();
        chk("len0_valid", int'(bit_valid), 0);

        // Reset in the middle of RUN, with ready low so no bit is consumed.
        bit_ready = 1'b0;
        start = 1'b1; frame_len = LEN_W'(20);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrun_valid", int'(bit_valid), 1);
        rst = 1'b1;
        tick();
        chk("midrun_rst_pn_rst", int'(pn_rst), 1);
        chk("midrun_rst_valid", int'(bit_valid), 0);
        chk("midrun_rst_busy", int'(busy), 0);
`ifdef PNSEQ_FRAME_CNT_EN
        exp_frames = 0;
        chk("midrun_rst_frame_cnt", int'(frame_cnt), 0);
`endif
        rst = 1'b0;
        tick();

        for (int f = 0; f < 24; f++) begin
            len = $urandom_range(1, 40);
            ab  = (($urandom % 4) == 0) ? $urandom_range(1, len) : 0;
            run_frame(len, ab, 1);
        end

        bit_ready = 1'b0;
        repeat (3) tick();
        chk("bits_left", exp_bits.size(), 0);
        chk("events_left", exp_ev.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
